// File: rtl/mic_pkg.sv
// Constants and types shared between the microphone frame assembler and the beam-summing adder tree.
package mic_pkg;
  localparam int MIC_NUM_CH   = 8;
  localparam int MIC_SAMPLE_W = 19;
  localparam int MIC_CH_W     = 3;

  typedef logic signed [MIC_SAMPLE_W-1:0] sample_t;
  typedef sample_t [MIC_NUM_CH-1:0]       frame_t;

  typedef enum logic {
    ASM_FILL = 1'b0,
    ASM_FULL = 1'b1
  } asm_state_e;
endpackage

// File: rtl/mic_frame_assembler_out_reg.sv
// Valid/ready holding register for one assembled frame; "free" tells the producer a load lands this cycle.
module frame_out_reg
  import mic_pkg::*;
#(
  parameter type frame_type = frame_t
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      load,
  input  frame_type load_data,
  output logic      free,
  output logic      m_valid,
  input  logic      m_ready,
  output frame_type m_data
);

  logic      vld_p0;
  frame_type data_p0;

  // Free when empty or being drained this cycle, so back-to-back frames see no bubble.
  assign free = !vld_p0 || m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
    end else if (load && free) begin
      vld_p0  <= 1'b1;
      data_p0 <= load_data;
    end else if (m_ready) begin
      vld_p0  <= 1'b0;
    end
  end

  assign m_valid = vld_p0;
  assign m_data  = data_p0;

endmodule

// File: rtl/mic_frame_assembler.sv
// Gathers time-multiplexed per-microphone samples into one parallel NUM_CH-lane frame for the adder tree.
module mic_frame_assembler
  import mic_pkg::*;
#(
  parameter int NUM_CH   = MIC_NUM_CH,
  parameter int SAMPLE_W = MIC_SAMPLE_W,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic signed [SAMPLE_W-1:0] s_data,
  input  logic [$clog2(NUM_CH)-1:0]  s_chan,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [NUM_CH*SAMPLE_W-1:0] m_data,
  output logic                       frame_err,
  output logic [CNT_W-1:0]           frame_cnt
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  typedef logic signed [SAMPLE_W-1:0] lane_t;
  typedef lane_t [NUM_CH-1:0]         frame_w_t;

  asm_state_e      state, state_nxt;
  logic [CH_W-1:0] exp_ch, exp_ch_nxt;
  frame_w_t        asm_buf, asm_buf_nxt;
  frame_w_t        out_frame;
  logic            accept, in_seq, last_lane, out_free, load, err_nxt;

  assign s_ready   = (state == ASM_FILL);
  assign accept    = s_valid && s_ready;
  assign in_seq    = accept && (s_chan == exp_ch);
  assign last_lane = in_seq && (exp_ch == LAST_CH);

  always_comb begin
    state_nxt   = state;
    exp_ch_nxt  = exp_ch;
    asm_buf_nxt = asm_buf;
    load        = 1'b0;
    err_nxt     = 1'b0;

    if (in_seq) begin
      asm_buf_nxt[exp_ch] = s_data;
      exp_ch_nxt          = exp_ch + 1'b1;
    end else if (accept) begin
      // Out-of-order channel: drop the partial frame; a channel-0 sample restarts assembly.
      err_nxt     = 1'b1;
      asm_buf_nxt = '0;
      if (s_chan == '0) begin
        asm_buf_nxt[0] = s_data;
        exp_ch_nxt     = CH_W'(1);
      end else begin
        exp_ch_nxt     = '0;
      end
    end

    case (state)
      ASM_FILL: begin
        if (last_lane) begin
          load = 1'b1;
          if (!out_free) state_nxt = ASM_FULL;
        end
      end
      ASM_FULL: begin
        load = 1'b1;
        if (out_free) state_nxt = ASM_FILL;
      end
      default: state_nxt = ASM_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ASM_FILL;
      exp_ch    <= '0;
      asm_buf   <= '0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_nxt;
      exp_ch    <= exp_ch_nxt;
      asm_buf   <= asm_buf_nxt;
      frame_err <= err_nxt;
      if (m_valid && m_ready) frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

  // Output stage: asm_buf_nxt already carries the final lane when the frame completes.
  frame_out_reg #(
    .frame_type (frame_w_t)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (asm_buf_nxt),
    .free      (out_free),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (out_frame)
  );

  assign m_data = out_frame;

endmodule

// File: tb/tb_mic_frame_assembler.sv
// Directed bench for mic_frame_assembler: vector table for sequencing/errors plus hand-written multi-cycle cases.
module tb_mic_frame_assembler;
  localparam int NCH = 8;
  localparam int SW  = 19;
  localparam int CW  = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 s_valid, s_ready, s_ready_w;
  logic signed [SW-1:0] s_data;
  logic [2:0]           s_chan;
  logic                 m_valid, m_valid_w, m_ready;
  logic [NCH*SW-1:0]    m_data, m_data_w;
  logic                 frame_err, frame_err_w;
  logic [CW-1:0]        frame_cnt;
  logic [1:0]           frame_cnt_w;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mic_frame_assembler #(.NUM_CH(NCH), .SAMPLE_W(SW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_chan(s_chan), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .frame_err(frame_err), .frame_cnt(frame_cnt)
  );

  // Narrow-counter copy so counter wrap can be reached in a few frames.
  mic_frame_assembler #(.NUM_CH(NCH), .SAMPLE_W(SW), .CNT_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_w), .s_data(s_data),
    .s_chan(s_chan), .m_valid(m_valid_w), .m_ready(m_ready), .m_data(m_data_w),
    .frame_err(frame_err_w), .frame_cnt(frame_cnt_w)
  );

  typedef struct {
    bit v;
    int ch;
    int base;
    bit mr;
    bit e_srdy;
    bit e_mv;
    bit e_err;
    int e_cnt;
    int e_fbase;
  } vec_t;

  vec_t tv[$];

  function automatic logic signed [SW-1:0] smp(int ch, int base);
    int v;
    v = (ch == NCH - 1) ? -(ch * 1000) : ch * 1000;
    return SW'(v + base);
  endfunction

  function automatic logic [NCH*SW-1:0] frm(int base);
    logic [NCH*SW-1:0] f;
    for (int k = 0; k < NCH; k++) f[k*SW +: SW] = smp(k, base);
    return f;
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int ch, input int base, input bit mr);
    s_valid = 1'b1;
    s_chan  = 3'(ch);
    s_data  = smp(ch, base);
    m_ready = mr;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    s_chan  = '0;
    s_data  = '0;
    m_ready = 1'b0;
    rst_n   = 1'b0;
    tick();
    tick();
    rst_n   = 1'b1;
    tick();
  endtask

  task automatic add(input bit v, input int ch, input int base, input bit mr, input bit sr,
                     input bit mv, input bit er, input int cnt, input int fb);
    vec_t t;
    t.v = v; t.ch = ch; t.base = base; t.mr = mr;
    t.e_srdy = sr; t.e_mv = mv; t.e_err = er; t.e_cnt = cnt; t.e_fbase = fb;
    tv.push_back(t);
  endtask

  initial begin
    logic [18:0] lane7_ref;
    lane7_ref = 19'h7E4A8;

    // Sequence-error vectors: 0,1,2,5 then clean 0..7, then 0,1,0 resync then 1..7.
    add(1, 0, 0, 1, 1, 0, 0, 0, -1);
    add(1, 1, 0, 1, 1, 0, 0, 0, -1);
    add(1, 2, 0, 1, 1, 0, 0, 0, -1);
    add(1, 5, 0, 1, 1, 0, 1, 0, -1);
    for (int c = 0; c < NCH; c++) add(1, c, 100, 1, 1, c == NCH - 1, 0, 0, (c == NCH - 1) ? 100 : -1);
    add(1, 0, 200, 1, 1, 0, 0, 1, -1);
    add(1, 1, 200, 1, 1, 0, 0, 1, -1);
    add(1, 0, 300, 1, 1, 0, 1, 1, -1);
    for (int c = 1; c < NCH; c++) add(1, c, 300, 1, 1, c == NCH - 1, 0, 1, (c == NCH - 1) ? 300 : -1);
    add(0, 0, 0, 1, 1, 0, 0, 2, -1);

    // 1: reset values and a single frame
    do_reset();
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    for (int c = 0; c < NCH; c++) begin
      send(c, 0, 1);
      chk("t1_m_valid", m_valid, c == NCH - 1);
    end
    chk("t1_frame", m_data, frm(0));
    chk("t1_lane7", m_data[7*SW +: SW], lane7_ref);
    tick();
    chk("t1_m_valid_drop", m_valid, 0);
    chk("t1_frame_cnt", frame_cnt, 1);

    // 2: three back-to-back frames, no bubbles
    for (int i = 0; i < 3 * NCH; i++) begin
      send(i % NCH, 10000 * (i / NCH + 1), 1);
      chk("t2_s_ready", s_ready, 1);
      chk("t2_m_valid", m_valid, (i % NCH) == NCH - 1);
      if ((i % NCH) == NCH - 1) chk("t2_frame", m_data, frm(10000 * (i / NCH + 1)));
    end
    tick();
    chk("t2_frame_cnt", frame_cnt, 4);
    chk("t2_m_valid_end", m_valid, 0);

    // 3: backpressure, hold stable, FULL state and release
    do_reset();
    for (int i = 0; i < 2 * NCH; i++) begin
      send(i % NCH, (i < NCH) ? 50 : 60, 0);
      chk("t3_s_ready", s_ready, i < 2 * NCH - 1);
      chk("t3_m_valid", m_valid, i >= NCH - 1);
      if (i >= NCH - 1) chk("t3_hold_data", m_data, frm(50));
    end
    s_valid = 1'b1; s_chan = 3'd0; s_data = smp(0, 90); m_ready = 1'b0;
    tick();
    s_valid = 1'b0;
    chk("t3_full_s_ready", s_ready, 0);
    chk("t3_full_data", m_data, frm(50));
    chk("t3_full_err", frame_err, 0);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    chk("t3_xfer_m_valid", m_valid, 1);
    chk("t3_xfer_data", m_data, frm(60));
    chk("t3_xfer_cnt", frame_cnt, 1);
    chk("t3_xfer_s_ready", s_ready, 1);
    tick();
    chk("t3_hold2_data", m_data, frm(60));
    chk("t3_hold2_cnt", frame_cnt, 1);

    // 4: table of sequence-error vectors
    do_reset();
    foreach (tv[i]) begin
      s_valid = tv[i].v;
      s_chan  = 3'(tv[i].ch);
      s_data  = smp(tv[i].ch, tv[i].base);
      m_ready = tv[i].mr;
      tick();
      chk($sformatf("vec%0d_s_ready", i), s_ready, tv[i].e_srdy);
      chk($sformatf("vec%0d_m_valid", i), m_valid, tv[i].e_mv);
      chk($sformatf("vec%0d_frame_err", i), frame_err, tv[i].e_err);
      chk($sformatf("vec%0d_frame_cnt", i), frame_cnt, tv[i].e_cnt);
      if (tv[i].e_fbase >= 0) chk($sformatf("vec%0d_frame", i), m_data, frm(tv[i].e_fbase));
    end
    s_valid = 1'b0;

    // 5: asynchronous reset with a frame pending and a partial frame
    for (int c = 0; c < NCH; c++) send(c, 500, 0);
    for (int c = 0; c < 4; c++) send(c, 600, 0);
    chk("t5_pending", m_valid, 1);
    rst_n = 1'b0;
    #2;
    chk("t5_async_m_valid", m_valid, 0);
    chk("t5_async_m_data", m_data, 0);
    chk("t5_async_cnt", frame_cnt, 0);
    chk("t5_async_s_ready", s_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    for (int c = 0; c < NCH; c++) begin
      send(c, 700, 1);
      chk("t5_no_err", frame_err, 0);
    end
    chk("t5_m_valid", m_valid, 1);
    chk("t5_frame", m_data, frm(700));
    tick();
    chk("t5_cnt", frame_cnt, 1);

    // 6: frame counter wrap on the narrow-counter instance
    do_reset();
    for (int f = 0; f < 5; f++) begin
      for (int c = 0; c < NCH; c++) send(c, 20 * f, 1);
      chk("t6_w_frame", m_data_w, frm(20 * f));
      tick();
      chk("t6_cnt_w", frame_cnt_w, (f + 1) % 4);
      chk("t6_cnt", frame_cnt, f + 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
